avalon_mm_word_copier: RTL

- Avalon-MM master (initiator) that copies a block of 32-bit words from a source address range to a destination address range, one word at a time.
- Intended to drive the on-chip memory slaves and other Avalon-MM slaves in the SoC, for example to move game/sprite state between RAM regions without NIOS involvement.
- A simple command port (start/count/addresses) is driven by a control register block; busy/done report status back.

---
 rtl/avalon_mm_word_copier.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/avalon_mm_word_copier.sv
// Avalon-MM master that copies a block of 32-bit words between
// address ranges, one read then one write per word.
module avalon_mm_word_copier #(
  parameter int ADDR_W       = 16,
  parameter int CNT_W        = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    DONE
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] cur_src;
  logic [ADDR_W-1:0] cur_dst;
  logic [CNT_W-1:0]  remaining;
  logic [2:0]        lat;
  logic [31:0]       data;
  logic              abort_q;
  logic              aborted_q;
  logic              abort_hit;
  logic              last_word;

  assign abort_hit = abort_q | abort;
  assign last_word = remaining == CNT_W'(1);
  assign aborted   = aborted_q;

  always_comb begin
    state_n        = state;
    busy           = 1'b0;
    done           = 1'b0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_byteenable = 4'h0;
    avm_writedata  = 32'h0;
    unique case (state)
      IDLE: begin
        if (start)
          state_n = (count == '0) ? DONE : RD_REQ;
      end
      RD_REQ: begin
        busy           = 1'b1;
        avm_read       = 1'b1;
        avm_address    = cur_src;
        avm_byteenable = 4'hF;
        if (!avm_waitrequest)
          state_n = RD_WAIT;
      end
      RD_WAIT: begin
        busy = 1'b1;
        if (lat == 3'd1)
          state_n = WR_REQ;
      end
      WR_REQ: begin
        busy           = 1'b1;
        avm_write      = 1'b1;
        avm_address    = cur_dst;
        avm_byteenable = 4'hF;
        avm_writedata  = data;
        // a completed count wins over a late abort
        if (!avm_waitrequest)
          state_n = (last_word || abort_hit) ? DONE : RD_REQ;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      lat       <= 3'd0;
      data      <= 32'h0;
      abort_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state <= state_n;
      if (busy)
        abort_q <= abort_q | abort;
      unique case (state)
        IDLE: begin
          if (start) begin
            cur_src   <= src_addr;
            cur_dst   <= dst_addr;
            remaining <= count;
            abort_q   <= 1'b0;
            aborted_q <= 1'b0;
          end
        end
        RD_REQ: begin
          if (!avm_waitrequest)
            lat <= 3'(READ_LATENCY);
        end
        RD_WAIT: begin
          lat <= lat - 3'd1;
          if (lat == 3'd1)
            data <= avm_readdata;
        end
        WR_REQ: begin
          if (!avm_waitrequest) begin
            cur_src   <= cur_src + ADDR_W'(4);
            cur_dst   <= cur_dst + ADDR_W'(4);
            remaining <= remaining - CNT_W'(1);
            if (!last_word && abort_hit)
              aborted_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
